// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared constants, FSM encoding and width helper for stream_mux_n
// Purpose: mode encodings, output-stage state type and the clog2 helper used to size channel indices.
// Contents: MODE_FIXED / MODE_RR, state_t {ST_EMPTY, ST_FULL}, clog2() with a minimum result of 1.
package stream_mux_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   // Index width for v channels; never below 1 so a 1-channel build still has a port.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      if (r < 1) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/stream_mux_n_rr_arbiter.sv
// rtl/stream_mux_n_rr_arbiter.sv - combinational round-robin arbiter
// Purpose: pick the first requesting channel after ptr, wrapping from CH-1 back to 0.
// Ports:
//   req         in  CH     request vector
//   ptr         in  SEL_W  last granted channel
//   grant_valid out 1      some channel is requesting
//   grant       out SEL_W  granted channel index
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter  int CH    = 4,
   localparam int SEL_W = clog2(CH)
) (
   input  logic [CH-1:0]    req,
   input  logic [SEL_W-1:0] ptr,
   output logic             grant_valid,
   output logic [SEL_W-1:0] grant
);

   // Two ascending passes: channels above ptr first, then the wrapped ones up to ptr.
   // The first hit in that order is the next channel in rotation.
   always_comb begin
      grant_valid = 1'b0;
      grant       = '0;
      for (int k = 0; k < CH; k++) begin
         if (!grant_valid && req[k] && (k > int'(ptr))) begin
            grant_valid = 1'b1;
            grant       = SEL_W'(k);
         end
      end
      for (int k = 0; k < CH; k++) begin
         if (!grant_valid && req[k] && (k <= int'(ptr))) begin
            grant_valid = 1'b1;
            grant       = SEL_W'(k);
         end
      end
   end

endmodule

// File: rtl/stream_mux_n.sv
// rtl/stream_mux_n.sv - N-channel valid/ready stream multiplexer with registered, channel-tagged output
// Purpose: select one of CH producer streams (fixed select or round-robin) into a one-word output register.
// Ports:
//   i_clk    in  1      clock, rising edge
//   i_rst    in  1      synchronous active-high reset
//   i_data   in  CH*n   channel k at [k*n +: n]
//   i_valid  in  CH     per-channel valid
//   o_ready  out CH     per-channel ready (combinational, one-hot or zero)
//   i_mode   in  1      0 fixed select, 1 round-robin
//   i_sel    in  SEL_W  channel used in fixed mode
//   o_Y      out n      registered data
//   o_ch     out SEL_W  source channel of o_Y
//   o_valid  out 1      output word valid
//   i_ready  in  1      consumer ready
module stream_mux_n
   import stream_mux_pkg::*;
#(
   parameter  int n     = 4,
   parameter  int CH    = 4,
   localparam int SEL_W = clog2(CH)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [CH*n-1:0]   i_data,
   input  logic [CH-1:0]     i_valid,
   output logic [CH-1:0]     o_ready,
   input  logic              i_mode,
   input  logic [SEL_W-1:0]  i_sel,
   output logic [n-1:0]      o_Y,
   output logic [SEL_W-1:0]  o_ch,
   output logic              o_valid,
   input  logic              i_ready
);

   state_t           state_q, state_d;
   logic [n-1:0]     y_q, y_d;
   logic [SEL_W-1:0] ch_q, ch_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [CH-1:0]    ready_vec;

   logic             rr_valid;
   logic [SEL_W-1:0] rr_grant;
   logic             fix_valid;
   logic             grant_valid;
   logic [SEL_W-1:0] grant;
   logic             load;

   rr_arbiter #(.CH(CH)) u_arb (
      .req         (i_valid),
      .ptr         (ptr_q),
      .grant_valid (rr_valid),
      .grant       (rr_grant)
   );

   // Out-of-range select yields no grant rather than aliasing onto another channel.
   assign fix_valid   = (int'(i_sel) < CH) && i_valid[i_sel];
   assign grant_valid = (i_mode == MODE_RR) ? rr_valid : fix_valid;
   assign grant       = (i_mode == MODE_RR) ? rr_grant : i_sel;

   // The register can take a new word when empty, or when the held one leaves this cycle.
   assign load = (state_q == ST_EMPTY) || i_ready;

   always_comb begin
      state_d   = state_q;
      y_d       = y_q;
      ch_d      = ch_q;
      ptr_d     = ptr_q;
      ready_vec = '0;
      if (load) begin
         if (grant_valid) begin
            state_d = ST_FULL;
            y_d     = i_data[int'(grant)*n +: n];
            ch_d    = grant;
            if (i_mode == MODE_RR) ptr_d = grant;
            for (int k = 0; k < CH; k++) ready_vec[k] = (int'(grant) == k);
         end else begin
            state_d = ST_EMPTY;
         end
      end
   end

   // No producer may see ready while the stage is being cleared.
   assign o_ready = i_rst ? '0 : ready_vec;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_EMPTY;
         y_q     <= '0;
         ch_q    <= '0;
         ptr_q   <= SEL_W'(CH - 1);
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         ch_q    <= ch_d;
         ptr_q   <= ptr_d;
      end
   end

   assign o_Y     = y_q;
   assign o_ch    = ch_q;
   assign o_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_stream_mux_n.sv
// tb/tb_stream_mux_n.sv - self-checking scoreboard bench for stream_mux_n
module tb_stream_mux_n;

   localparam int N  = 4;
   localparam int CH = 4;
   localparam int SW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [CH*N-1:0] data;
   logic [CH-1:0]   valid;
   logic [CH-1:0]   o_ready;
   logic            mode;
   logic [SW-1:0]   sel;
   logic [N-1:0]    o_Y;
   logic [SW-1:0]   o_ch;
   logic            o_valid;
   logic            rdy;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [N-1:0] y;
      int           ch;
   } exp_t;
   exp_t sb[$];

   bit m_full    = 1'b0;
   int m_ptr     = CH - 1;
   bit m_rst_chk = 1'b0;

   stream_mux_n #(.n(N), .CH(CH)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_data  (data),
      .i_valid (valid),
      .o_ready (o_ready),
      .i_mode  (mode),
      .i_sel   (sel),
      .o_Y     (o_Y),
      .o_ch    (o_ch),
      .o_valid (o_valid),
      .i_ready (rdy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model evaluated mid-cycle, then advanced to mirror the next rising edge.
   always @(negedge clk) begin
      bit          gv;
      int          g;
      int          c;
      bit          ld;
      logic [CH-1:0] er;
      gv = 1'b0;
      g  = 0;
      if (mode) begin
         for (int i = 1; i <= CH; i++) begin
            c = (m_ptr + i) % CH;
            if (!gv && valid[c]) begin
               gv = 1'b1;
               g  = c;
            end
         end
      end else if (int'(sel) < CH && valid[sel]) begin
         gv = 1'b1;
         g  = int'(sel);
      end
      ld = !m_full || rdy;
      er = (!rst && ld && gv) ? CH'(1 << g) : '0;
      check("o_ready", 32'(o_ready), 32'(er));
      check("o_valid", 32'(o_valid), 32'(m_full));
      if (m_full && sb.size() > 0) begin
         check("o_Y", 32'(o_Y), 32'(sb[0].y));
         check("o_ch", 32'(o_ch), 32'(sb[0].ch));
      end
      if (m_rst_chk) begin
         check("rst_o_Y", 32'(o_Y), 32'd0);
         check("rst_o_ch", 32'(o_ch), 32'd0);
         m_rst_chk = 1'b0;
      end
      if (rst) begin
         sb.delete();
         m_full    = 1'b0;
         m_ptr     = CH - 1;
         m_rst_chk = 1'b1;
      end else if (ld) begin
         if (m_full && sb.size() > 0) void'(sb.pop_front());
         if (gv) begin
            sb.push_back('{y: data[g*N +: N], ch: g});
            m_full = 1'b1;
            if (mode) m_ptr = g;
         end else begin
            m_full = 1'b0;
         end
      end
   end

   task automatic step(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst = 1'b1; data = '0; valid = '0; mode = 1'b0; sel = '0; rdy = 1'b1;
      step(2);
      rst = 1'b0;
      step(1);
      // fixed select, channel 2
      sel = 2'd2; valid = 4'b0100; data = 16'h0A00;
      step(1);
      valid = '0;
      step(2);
      // fixed select on an idle channel, then it becomes valid
      sel = 2'd1; valid = 4'b1101; data = 16'h0000;
      step(2);
      valid = 4'b1111; data = 16'h0030;
      step(1);
      valid = '0;
      step(2);
      // round-robin from reset, full throughput
      rst = 1'b1;
      step(1);
      rst = 1'b0; mode = 1'b1; valid = 4'b1111; data = 16'h8765;
      step(8);
      valid = '0;
      step(1);
      // load ch2 (7), stall three cycles, then release
      valid = 4'b0100;
      step(1);
      rdy = 1'b0; valid = 4'b1111;
      step(3);
      rdy = 1'b1;
      step(2);
      valid = '0;
      step(2);
      // only ch1 and ch3 requesting
      valid = 4'b1010;
      step(4);
      valid = '0;
      step(2);
      // reset while holding 4'hC
      valid = 4'b1111; data = 16'hCCCC;
      step(1);
      rdy = 1'b0;
      step(1);
      rst = 1'b1;
      step(1);
      rst = 1'b0; rdy = 1'b1; data = 16'h8765;
      step(1);
      valid = '0;
      step(2);
      // random traffic
      for (int i = 0; i < 300; i++) begin
         valid = CH'($urandom_range(0, 15));
         data  = 16'($urandom);
         rdy   = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) mode = ~mode;
         sel   = SW'($urandom_range(0, 3));
         rst   = ($urandom_range(0, 63) == 0);
         step(1);
      end
      rst = 1'b0; valid = '0; rdy = 1'b1;
      step(3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stream_mux_n.md
Name: stream_mux_n

Overview:
- Parametrised successor to the 2-input combinational multiplexer: N input channels of n-bit data, each with a valid/ready handshake.
- One registered output stage, also with valid/ready.
- Two selection modes: fixed select (i_sel) or round-robin arbitration.
- Sits between multiple producer streams and a single consumer; the output word is tagged with its source channel.

Parameters:
- n, 4, data width per channel.
- CH, 4, number of input channels (2..16).
- SEL_W, clog2(CH) (min 1), width of channel index; derived, not overridden.

Ports:
- i_clk  in  1  single clock, rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_data  in  CH*n  channel k occupies bits [k*n +: n].
- i_valid  in  CH  per-channel valid.
- o_ready  out  CH  per-channel ready; combinational.
- i_mode  in  1  0 = fixed select, 1 = round-robin.
- i_sel  in  SEL_W  channel index used when i_mode=0.
- o_Y  out  n  registered output data.
- o_ch  out  SEL_W  source channel of o_Y.
- o_valid  out  1  o_Y/o_ch valid.
- i_ready  in  1  consumer ready.

Behaviour:
- Reset (i_rst=1 at rising edge):
  - o_valid=0, o_Y=0, o_ch=0.
  - Round-robin pointer = CH-1, so channel 0 has first priority.
  - o_ready = 0 during the reset cycle.
- Output stage is a 2-state FSM:
  - EMPTY (o_valid=0) and FULL (o_valid=1).
  - load = EMPTY | (FULL & i_ready).
- Grant:
  - Mode 0: grant channel i_sel iff i_valid[i_sel]=1. If i_sel >= CH, there is no grant.
  - Mode 1: grant the first channel with i_valid=1, searching from pointer+1 upward and wrapping at CH-1 -> 0.
- Handshake:
  - o_ready[k] = load & grant_valid & (grant==k).
  - At most one o_ready bit is high per cycle.
  - A transfer on channel k occurs when i_valid[k] & o_ready[k].
- Transfer (on the clock edge): o_Y <= i_data[k], o_ch <= k, o_valid <= 1. Latency input->output is 1 cycle.
  - In mode 1, pointer <= k. In mode 0, the pointer is unchanged.
- FULL & i_ready & no grant -> o_valid <= 0 (go EMPTY).
- FULL & ~i_ready -> o_Y, o_ch and o_valid are held stable; all o_ready = 0.
- Throughput: one word per cycle when the consumer holds i_ready=1 and inputs are continuously valid (output consumed and reloaded in the same cycle).
- i_mode and i_sel are sampled combinationally every cycle. A change affects only the next grant; a word already held is never altered.
- Reset mid-operation: a held word is discarded, and the pointer returns to CH-1 regardless of state.
- A producer may drop i_valid without transfer; no state changes as a result.

Decomposition:
- Shared package (stream_mux_pkg):
  - MODE_FIXED=1'b0, MODE_RR=1'b1.
  - clog2 function for SEL_W.
  - FSM state encodings ST_EMPTY, ST_FULL.
- Sub-module rr_arbiter (parameter CH):
  - Inputs: request vector, pointer.
  - Outputs: grant_valid, grant index.
  - Purely combinational; instantiated once.
- Output register, FSM and pointer register stay in stream_mux_n.

Test Plan:
- Mode 0, i_sel=2, i_valid=4'b0100, i_data ch2=4'hA, i_ready=1 -> next cycle o_valid=1, o_Y=4'hA, o_ch=2; o_ready=4'b0100 in the transfer cycle.
- Mode 0, i_sel=1, i_valid=4'b1101 (ch1 idle) -> o_ready=0000 and o_valid stays 0; then assert i_valid[1] with data 4'h3 -> o_Y=4'h3, o_ch=1 one cycle later.
- Mode 1 after reset, all i_valid=1, data ch k=k+5, i_ready=1 for 8 cycles -> o_ch sequence 0,1,2,3,0,1,2,3 and o_Y 5,6,7,8,5,6,7,8 with o_valid=1 every cycle.
- Mode 1, FULL with o_Y=4'h7, i_ready=0 for 3 cycles -> o_Y/o_ch/o_valid unchanged, o_ready=0000; i_ready=1 -> the next channel in round-robin order loads the same cycle.
- Mode 1, i_valid=4'b1010 -> grants alternate ch1, ch3, ch1; ch0 and ch2 never get o_ready.
- Reset asserted while FULL (o_Y=4'hC) -> next cycle o_valid=0, o_Y=0, o_ch=0; the first round-robin grant with all valid goes to ch0.
